// File: rtl/uart_rx_core.sv
// Oversampled UART receiver with programmable divider, LSB-first data and valid/ready output.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
    parameter int CLK_DIV    = 27,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    // state  | meaning
    // IDLE   | line idle, waiting for a 1->0 edge on rxd_s
    // START  | timing to mid start bit to confirm it is still low
    // DATA   | sampling DATA_BITS data bits at mid-bit, LSB first
    // PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
    // STOP   | sampling mid stop bit, then deliver / flag the word
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);

    if ((OVS % 2) != 0 || OVS < 4) begin : g_bad_ovs
        $error("uart_rx_core: OVS must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_rx_core: PARITY_ODD must be 0 or 1");
    end

    state_t                 state;
    logic                   rxd_m;
    logic                   rxd_s;
    logic                   rxd_q;
    logic [TW-1:0]          tick_cnt;
    logic [OW-1:0]          ovs_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bad;
    logic                   tick;
    logic                   ovs_last;
    logic                   ovs_half;

    assign tick     = (tick_cnt == TW'(CLK_DIV - 1));
    assign ovs_last = (ovs_cnt == OW'(OVS - 1));
    assign ovs_half = (ovs_cnt == OW'(OVS / 2 - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_q      <= 1'b1;
            tick_cnt   <= '0;
            ovs_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            rxd_q      <= rxd_s;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;

            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // Held at 0 in IDLE so the first tick lands CLK_DIV cycles after the edge.
            if (state == IDLE || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rxd_q && !rxd_s) begin
                        state   <= START;
                        ovs_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (ovs_half) begin
                            ovs_cnt <= '0;
                            if (!rxd_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                par_bad <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            ovs_cnt <= ovs_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (ovs_last) begin
                            ovs_cnt   <= '0;
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            ovs_cnt <= ovs_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (ovs_last) begin
                            ovs_cnt <= '0;
                            state   <= STOP;
                            // Ones across data plus parity bit must be even (or odd).
                            if ((^shift_reg ^ rxd_s) != (PARITY_ODD != 0)) begin
                                par_bad    <= 1'b1;
                                parity_err <= 1'b1;
                            end
                        end else begin
                            ovs_cnt <= ovs_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (ovs_last) begin
                            ovs_cnt <= '0;
                            state   <= IDLE;
                            if (!rxd_s) begin
                                frame_err <= 1'b1;
                            end else if (!par_bad) begin
                                if (!data_valid || data_ready) begin
                                    data       <= shift_reg;
                                    data_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end else begin
                            ovs_cnt <= ovs_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLK_DIV=4, OVS=16 (64 clk per bit).
module tb_uart_rx_core;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int         n_rx  = 0;
    int         n_vld = 0;
    int         n_fe  = 0;
    int         n_pe  = 0;
    int         n_ovr = 0;
    logic [7:0] last_data = 8'h00;

    int b_rx, b_vld, b_fe, b_pe, b_ovr, pe_start;

    uart_rx_core #(
        .CLK_DIV   (4),
        .OVS       (16),
        .DATA_BITS (8),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_rst) begin
            if (data_valid) n_vld <= n_vld + 1;
            if (data_valid && data_ready) begin
                n_rx      <= n_rx + 1;
                last_data <= data;
            end
            if (frame_err)  n_fe  <= n_fe + 1;
            if (parity_err) n_pe  <= n_pe + 1;
            if (overrun)    n_ovr <= n_ovr + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rx  = n_rx;
        b_vld = n_vld;
        b_fe  = n_fe;
        b_pe  = n_pe;
        b_ovr = n_ovr;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit,
                        input logic use_par, input logic par_bit);
        rxd = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            step(BIT);
        end
        if (use_par) begin
            rxd = par_bit;
            step(BIT);
        end
        rxd = stop_bit;
        step(BIT);
        rxd = 1'b1;
        step(20);
    endtask

    initial begin
        n_rst      = 1'b0;
        rxd        = 1'b1;
        data_ready = 1'b1;
        step(3);
        @(negedge clk);
        chk("reset data", 32'(data), 32'h0);
        chk("reset data_valid", 32'(data_valid), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset parity_err", 32'(parity_err), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        n_rst = 1'b1;
        step(10);
        pe_start = n_pe;

        // 1: clean frames with the consumer always ready
        snap();
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t1 rx count", 32'(n_rx - b_rx), 32'd1);
        chk("t1 data", 32'(last_data), 32'hA5);
        chk("t1 valid width", 32'(n_vld - b_vld), 32'd1);
        chk("t1 frame_err", 32'(n_fe - b_fe), 32'd0);
        chk("t1 overrun", 32'(n_ovr - b_ovr), 32'd0);
        snap();
        send(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t1b rx count", 32'(n_rx - b_rx), 32'd1);
        chk("t1b data", 32'(last_data), 32'h00);

        // 2: short low glitch is rejected
        snap();
        rxd = 1'b0;
        step(20);
        rxd = 1'b1;
        step(2 * BIT);
        chk("t2 no valid", 32'(n_vld - b_vld), 32'd0);
        chk("t2 no frame_err", 32'(n_fe - b_fe), 32'd0);
        chk("t2 data_valid", 32'(data_valid), 32'h0);

        // 3: stop bit low
        snap();
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t3 frame_err pulse", 32'(n_fe - b_fe), 32'd1);
        chk("t3 no valid", 32'(n_vld - b_vld), 32'd0);
        chk("t3 data_valid", 32'(data_valid), 32'h0);

        // 4: consumer stalled, second word overruns
        data_ready = 1'b0;
        snap();
        send(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        chk("t4 overrun pulse", 32'(n_ovr - b_ovr), 32'd1);
        chk("t4 data held", 32'(data), 32'h11);
        chk("t4 valid held", 32'(data_valid), 32'h1);
        chk("t4 no handshake", 32'(n_rx - b_rx), 32'd0);
        data_ready = 1'b1;
        @(negedge clk);
        chk("t4 valid before edge", 32'(data_valid), 32'h1);
        @(negedge clk);
        chk("t4 valid cleared", 32'(data_valid), 32'h0);
        chk("t4 accepted word", 32'(last_data), 32'h11);
        step(5);

        // 5: reset in the middle of 0xFF
        rxd = 1'b0;
        step(BIT);
        rxd = 1'b1;
        step(4 * BIT + BIT / 2);
        n_rst = 1'b0;
        step(3);
        @(negedge clk);
        chk("t5 reset data_valid", 32'(data_valid), 32'h0);
        chk("t5 reset data", 32'(data), 32'h0);
        n_rst = 1'b1;
        step(10);
        snap();
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("t5 rx count", 32'(n_rx - b_rx), 32'd1);
        chk("t5 data", 32'(last_data), 32'h5A);
        chk("t5 frame_err", 32'(n_fe - b_fe), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity
        snap();
        send(8'h07, 1'b1, 1'b1, 1'b1);
        chk("t6 good parity rx", 32'(n_rx - b_rx), 32'd1);
        chk("t6 good parity data", 32'(last_data), 32'h07);
        chk("t6 good parity flag", 32'(n_pe - b_pe), 32'd0);
        snap();
        send(8'h07, 1'b1, 1'b1, 1'b0);
        chk("t6 parity_err pulse", 32'(n_pe - b_pe), 32'd1);
        chk("t6 bad parity no valid", 32'(n_vld - b_vld), 32'd0);
`else
        chk("parity_err never set", 32'(n_pe - pe_start), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
